tpu_job_scheduler: RTL and testbench
====================================

Name: tpu_job_scheduler

Overview:
- Queues systolic-array job descriptors from the host/DMA side over a valid/ready interface.
- Sequences them one at a time into the systolic controller: latches the SRAM base addresses, pulses tpu_start, waits for tpu_done.
- Returns one completion record per job over a second valid/ready interface.
- Sits between the host command interface and the systolic controller and its address-select logic.

Parameters:
- QUEUE_DEPTH, 4, descriptor FIFO entries; power of 2, minimum 2.
- ADDR_W, 10, width of the source and destination SRAM base addresses.
- JOB_ID_W, 4, width of the job tag.
- TIMEOUT_CYCLES, 1024, watchdog limit in RUN; used only with the optional feature.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- srstn  in  1  synchronous active-low reset.
- job_valid  in  1  descriptor offered.
- job_ready  out  1  descriptor can be accepted; equals !full.
- job_src_addr  in  ADDR_W  source-SRAM base for the job.
- job_dst_addr  in  ADDR_W  result-SRAM base for the job.
- job_id  in  JOB_ID_W  tag echoed on completion.
- tpu_start  out  1  one-cycle start pulse to the systolic controller.
- tpu_done  in  1  done pulse from the systolic controller.
- tpu_abort  out  1  one-cycle abort pulse; watchdog only.
- tpu_src_base  out  ADDR_W  base address held stable for the running job.
- tpu_dst_base  out  ADDR_W  base address held stable for the running job.
- cmpl_valid  out  1  completion record valid.
- cmpl_ready  in  1  completion consumer ready.
- cmpl_id  out  JOB_ID_W  tag of the completed job.
- cmpl_err  out  1  job terminated by the watchdog.
- busy  out  1  high when state is not IDLE or the queue is non-empty.
- queue_level  out  $clog2(QUEUE_DEPTH)+1  FIFO occupancy.
- done_count  out  16  count of completions handed off; wraps 0xFFFF to 0.

Behaviour:
- Reset: when srstn is low at a clock edge, the following are cleared: state=IDLE, FIFO pointers and level=0, tpu_start=0, tpu_abort=0, tpu_src_base=0, tpu_dst_base=0, cmpl_valid=0, cmpl_id=0, cmpl_err=0, done_count=0, watchdog counter=0.
  - job_ready is 1 during and after reset.
  - Reset mid-job drops all queued and in-flight jobs, with no completion records.
- FIFO:
  - Push when job_valid && job_ready.
  - Pop only on the IDLE->ISSUE transition.
  - Push and pop in the same cycle leave the level unchanged; allowed when full because job_ready reflects the current, not the next, level.
  - Pointers wrap modulo QUEUE_DEPTH.
- FSM states: IDLE, ISSUE, RUN, CMPL.
  - IDLE: if level>0, pop the head, latch tpu_src_base, tpu_dst_base and the current id, then go to ISSUE. Otherwise stay.
  - ISSUE: tpu_start=1 for exactly this cycle (decoded from the registered state); go to RUN.
  - RUN: tpu_start=0. On tpu_done=1, set cmpl_valid=1, cmpl_id=current id, cmpl_err=0, and go to CMPL.
  - CMPL: hold cmpl_valid and the record stable until cmpl_ready=1. On that cycle, clear cmpl_valid, increment done_count, and go to IDLE.
- Latency, single job on an idle, empty block:
  - Accepted at edge k.
  - Popped at edge k+1.
  - tpu_start high between edges k+1 and k+2.
  - Minimum spacing between consecutive tpu_start pulses is 4 cycles, which guarantees the controller sees start only while in its own IDLE.
- tpu_done is ignored in IDLE, ISSUE and CMPL: no state change, no record.
- tpu_src_base and tpu_dst_base change only on a pop; they hold their value after completion.
- Pushes continue in all states while not full.

Optional Feature:
- Macro: TPU_JOB_WATCHDOG_EN.
- Defined:
  - A counter clears on ISSUE and increments every RUN cycle.
  - If it reaches TIMEOUT_CYCLES-1 with tpu_done=0, then at the next edge tpu_abort=1 for one cycle, cmpl_valid=1, cmpl_err=1, and state goes to CMPL.
  - tpu_done in that same final cycle wins: normal completion with cmpl_err=0, no abort.
- Not defined: no counter; tpu_abort and cmpl_err tied 0; RUN waits indefinitely.

Test Plan:
- Single job: push src=0x010, dst=0x200, id=3 at edge 0.
  - tpu_start high only in cycle 1–2, with tpu_src_base=0x010 and tpu_dst_base=0x200.
  - Drive tpu_done 20 cycles later with cmpl_ready=1: cmpl_valid for one cycle with cmpl_id=3, cmpl_err=0; done_count=1; busy=0 afterwards.
- Queue full: push 5 jobs back-to-back while tpu_done is held off.
  - First job is popped, then 4 queue; job_ready=0 with queue_level=4.
  - 6th offer is not accepted until the first completion's pop frees a slot.
  - Jobs complete in id order 0..4.
- Backpressure: hold cmpl_ready=0 for 10 cycles.
  - cmpl_valid and cmpl_id stay stable.
  - No second tpu_start is issued while the record is pending.
- Spurious done: tpu_done pulses in IDLE and in the ISSUE cycle.
  - No completion record and no state change.
- Watchdog (macro defined, TIMEOUT_CYCLES=16): never assert tpu_done.
  - tpu_abort pulses once, 16 cycles after entering RUN.
  - Completion has cmpl_err=1; the next queued job then starts normally.
- Reset mid-RUN with 2 jobs queued: pull srstn low for one edge.
  - All outputs return to reset values; queue_level=0.
  - Later tpu_done produces no record.

Source files
------------

// File: rtl/tpu_job_scheduler.sv
// rtl/tpu_job_scheduler.sv - job descriptor queue and sequencer for the systolic-array controller
//
// Purpose:
//   Accepts job descriptors (source/destination SRAM bases plus a tag) into a
//   small FIFO and runs them one at a time on the systolic controller. For each
//   job it latches the base addresses, pulses tpu_start, waits for tpu_done and
//   hands back one completion record over a valid/ready interface.
//
// Optional feature:
//   TPU_JOB_WATCHDOG_EN - when defined, a RUN-state watchdog aborts a job that
//   has not signalled tpu_done within TIMEOUT_CYCLES cycles. The job then
//   completes with cmpl_err=1 and tpu_abort pulses for one cycle. When
//   undefined, tpu_abort and cmpl_err are tied low and RUN waits indefinitely.
//
// Ports:
//   clk, srstn           clock and synchronous active-low reset
//   job_valid/job_ready  descriptor handshake (job_ready = !full)
//   job_src_addr         source-SRAM base of the offered job
//   job_dst_addr         result-SRAM base of the offered job
//   job_id               tag echoed on completion
//   tpu_start            one-cycle start pulse to the systolic controller
//   tpu_done             done pulse from the systolic controller
//   tpu_abort            one-cycle abort pulse (watchdog only)
//   tpu_src_base         source base held stable for the running job
//   tpu_dst_base         destination base held stable for the running job
//   cmpl_valid/ready     completion record handshake
//   cmpl_id, cmpl_err    completion record contents
//   busy                 a job is in flight or the queue is non-empty
//   queue_level          FIFO occupancy
//   done_count           completions handed off, wraps at 16 bits
module tpu_job_scheduler #(
  parameter int QUEUE_DEPTH    = 4,
  parameter int ADDR_W         = 10,
  parameter int JOB_ID_W       = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                         clk,
  input  logic                         srstn,
  input  logic                         job_valid,
  output logic                         job_ready,
  input  logic [ADDR_W-1:0]            job_src_addr,
  input  logic [ADDR_W-1:0]            job_dst_addr,
  input  logic [JOB_ID_W-1:0]          job_id,
  output logic                         tpu_start,
  input  logic                         tpu_done,
  output logic                         tpu_abort,
  output logic [ADDR_W-1:0]            tpu_src_base,
  output logic [ADDR_W-1:0]            tpu_dst_base,
  output logic                         cmpl_valid,
  input  logic                         cmpl_ready,
  output logic [JOB_ID_W-1:0]          cmpl_id,
  output logic                         cmpl_err,
  output logic                         busy,
  output logic [$clog2(QUEUE_DEPTH):0] queue_level,
  output logic [15:0]                  done_count
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RUN   = 2'd2,
    ST_CMPL  = 2'd3
  } state_t;

  state_t              state_q, state_d;

  // descriptor FIFO
  logic [ADDR_W-1:0]   src_mem [QUEUE_DEPTH];
  logic [ADDR_W-1:0]   dst_mem [QUEUE_DEPTH];
  logic [JOB_ID_W-1:0] id_mem  [QUEUE_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    level_q, level_d;

  // running job and completion record
  logic [ADDR_W-1:0]   src_base_q, src_base_d;
  logic [ADDR_W-1:0]   dst_base_q, dst_base_d;
  logic [JOB_ID_W-1:0] cur_id_q, cur_id_d;
  logic                cmpl_valid_q, cmpl_valid_d;
  logic [JOB_ID_W-1:0] cmpl_id_q, cmpl_id_d;
  logic [15:0]         done_count_q, done_count_d;

  logic                full;
  logic                push;
  logic                pop;
  logic                wdog_fire;

  assign full = (level_q == LVL_W'(QUEUE_DEPTH));

  // Ready is forced high while reset is asserted so it never reads as
  // stalled before the first reset edge has cleared the level register.
  assign job_ready = ~full | ~srstn;
  assign push      = job_valid & job_ready;

  // The head is consumed only when the sequencer leaves IDLE.
  assign pop = (state_q == ST_IDLE) && (level_q != '0);

  // FIFO storage needs no reset: entries are only read below the level.
  always_ff @(posedge clk) begin
    if (push) begin
      src_mem[wr_ptr_q] <= job_src_addr;
      dst_mem[wr_ptr_q] <= job_dst_addr;
      id_mem[wr_ptr_q]  <= job_id;
    end
  end

  // FIFO pointer and level update. Push and pop together are allowed even
  // when full, since readiness reflects the level before this edge.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    unique case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Sequencer next-state and record logic.
  always_comb begin
    state_d      = state_q;
    src_base_d   = src_base_q;
    dst_base_d   = dst_base_q;
    cur_id_d     = cur_id_q;
    cmpl_valid_d = cmpl_valid_q;
    cmpl_id_d    = cmpl_id_q;
    done_count_d = done_count_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pop) begin
          src_base_d = src_mem[rd_ptr_q];
          dst_base_d = dst_mem[rd_ptr_q];
          cur_id_d   = id_mem[rd_ptr_q];
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        // tpu_done in the same cycle as the watchdog limit is a normal finish.
        if (tpu_done || wdog_fire) begin
          cmpl_valid_d = 1'b1;
          cmpl_id_d    = cur_id_q;
          state_d      = ST_CMPL;
        end
      end
      ST_CMPL: begin
        if (cmpl_ready) begin
          cmpl_valid_d = 1'b0;
          done_count_d = done_count_q + 16'd1;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!srstn) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      src_base_q   <= '0;
      dst_base_q   <= '0;
      cur_id_q     <= '0;
      cmpl_valid_q <= 1'b0;
      cmpl_id_q    <= '0;
      done_count_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      src_base_q   <= src_base_d;
      dst_base_q   <= dst_base_d;
      cur_id_q     <= cur_id_d;
      cmpl_valid_q <= cmpl_valid_d;
      cmpl_id_q    <= cmpl_id_d;
      done_count_q <= done_count_d;
    end
  end

`ifdef TPU_JOB_WATCHDOG_EN
  localparam int WDOG_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              tpu_abort_q, tpu_abort_d;
  logic              cmpl_err_q, cmpl_err_d;

  // Fires on the RUN cycle where the count has reached its limit and the
  // controller has still not reported done.
  assign wdog_fire = (state_q == ST_RUN) && !tpu_done &&
                     (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wdog_d      = wdog_q;
    tpu_abort_d = wdog_fire;
    cmpl_err_d  = cmpl_err_q;
    if (state_q == ST_ISSUE) begin
      wdog_d = '0;
    end else if ((state_q == ST_RUN) && !wdog_fire) begin
      wdog_d = wdog_q + WDOG_W'(1);
    end
    if (state_q == ST_RUN) begin
      if (tpu_done) begin
        cmpl_err_d = 1'b0;
      end else if (wdog_fire) begin
        cmpl_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!srstn) begin
      wdog_q      <= '0;
      tpu_abort_q <= 1'b0;
      cmpl_err_q  <= 1'b0;
    end else begin
      wdog_q      <= wdog_d;
      tpu_abort_q <= tpu_abort_d;
      cmpl_err_q  <= cmpl_err_d;
    end
  end

  assign tpu_abort = tpu_abort_q;
  assign cmpl_err  = cmpl_err_q;
`else
  assign wdog_fire = 1'b0;
  assign tpu_abort = 1'b0;
  assign cmpl_err  = 1'b0;
`endif

  // Start is decoded from the registered state, so it is high for exactly
  // the single ISSUE cycle.
  assign tpu_start    = (state_q == ST_ISSUE);
  assign tpu_src_base = src_base_q;
  assign tpu_dst_base = dst_base_q;
  assign cmpl_valid   = cmpl_valid_q;
  assign cmpl_id      = cmpl_id_q;
  assign busy         = (state_q != ST_IDLE) || (level_q != '0);
  assign queue_level  = level_q;
  assign done_count   = done_count_q;

endmodule

// File: tb/tb_tpu_job_scheduler.sv
// tb/tb_tpu_job_scheduler.sv - randomized self-checking bench for tpu_job_scheduler
module tb_tpu_job_scheduler;

  localparam int DEPTH = 4;
  localparam int TO    = 16;
`ifdef TPU_JOB_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        srstn;
  logic        jv;
  logic        job_ready;
  logic [9:0]  jsrc, jdst;
  logic [3:0]  jid;
  logic        tpu_start, done, tpu_abort;
  logic [9:0]  tpu_src_base, tpu_dst_base;
  logic        cmpl_valid, cr;
  logic [3:0]  cmpl_id;
  logic        cmpl_err, busy;
  logic [2:0]  queue_level;
  logic [15:0] done_count;

  always #5 clk = ~clk;

  tpu_job_scheduler #(
    .QUEUE_DEPTH(DEPTH), .ADDR_W(10), .JOB_ID_W(4), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .srstn(srstn),
    .job_valid(jv), .job_ready(job_ready),
    .job_src_addr(jsrc), .job_dst_addr(jdst), .job_id(jid),
    .tpu_start(tpu_start), .tpu_done(done), .tpu_abort(tpu_abort),
    .tpu_src_base(tpu_src_base), .tpu_dst_base(tpu_dst_base),
    .cmpl_valid(cmpl_valid), .cmpl_ready(cr), .cmpl_id(cmpl_id), .cmpl_err(cmpl_err),
    .busy(busy), .queue_level(queue_level), .done_count(done_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Transaction-level reference: a queue of waiting jobs, the job in hand,
  // and flags for "start still to show", "record outstanding".
  typedef struct {
    logic [9:0] src;
    logic [9:0] dst;
    logic [3:0] id;
  } job_t;

  job_t        jq[$];
  job_t        cur;
  bit          m_active, m_start, m_rec, m_rec_err, m_abort;
  logic [3:0]  m_rec_id;
  logic [9:0]  m_src, m_dst;
  logic [15:0] m_done_cnt;
  int          m_run;

  task automatic model_edge();
    int sz;
    bit do_push;
    m_abort = 1'b0;
    if (!srstn) begin
      jq.delete();
      m_active = 0; m_start = 0; m_rec = 0; m_rec_err = 0;
      m_rec_id = '0; m_src = '0; m_dst = '0; m_done_cnt = '0; m_run = 0;
    end else begin
      sz = jq.size();
      do_push = jv && (sz < DEPTH);
      if (!m_active) begin
        if (sz > 0) begin
          cur = jq.pop_front();
          m_src = cur.src; m_dst = cur.dst;
          m_active = 1; m_start = 1;
        end
      end else if (m_start) begin
        m_start = 0; m_run = 0;
      end else if (!m_rec) begin
        if (done) begin
          m_rec = 1; m_rec_id = cur.id; m_rec_err = 0;
        end else if (WD && m_run == TO - 1) begin
          m_rec = 1; m_rec_id = cur.id; m_rec_err = 1; m_abort = 1;
        end else begin
          m_run++;
        end
      end else if (cr) begin
        m_rec = 0; m_active = 0; m_done_cnt = m_done_cnt + 16'd1;
      end
      if (do_push) jq.push_back('{src: jsrc, dst: jdst, id: jid});
    end
  endtask

  task automatic compare_all();
    check("job_ready",   job_ready,    jq.size() < DEPTH);
    check("queue_level", queue_level,  jq.size());
    check("busy",        busy,         m_active || (jq.size() != 0));
    check("tpu_start",   tpu_start,    m_active && m_start);
    check("tpu_abort",   tpu_abort,    m_abort);
    check("src_base",    tpu_src_base, m_src);
    check("dst_base",    tpu_dst_base, m_dst);
    check("cmpl_valid",  cmpl_valid,   m_rec);
    check("cmpl_id",     cmpl_id,      m_rec_id);
    check("cmpl_err",    cmpl_err,     m_rec_err);
    check("done_count",  done_count,   m_done_cnt);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #2;
    compare_all();
  endtask

  int exp_id;
  int aborts;

  initial begin
    srstn = 1'b0; jv = 1'b0; jsrc = '0; jdst = '0; jid = '0; done = 1'b0; cr = 1'b1;
    #1;
    check("ready_in_reset", job_ready, 1);
    repeat (2) tick();
    srstn = 1'b1;

    // single job and its latency
    jv = 1'b1; jsrc = 10'h010; jdst = 10'h200; jid = 4'd3;
    tick();
    jv = 1'b0;
    check("single_no_early_start", tpu_start, 0);
    tick();
    check("single_start", tpu_start, 1);
    check("single_src", tpu_src_base, 10'h010);
    check("single_dst", tpu_dst_base, 10'h200);
    tick();
    check("single_start_one_cycle", tpu_start, 0);
    repeat (18) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    check("single_cmpl_valid", cmpl_valid, 1);
    check("single_cmpl_id", cmpl_id, 3);
    tick();
    check("single_cmpl_gone", cmpl_valid, 0);
    check("single_count", done_count, 1);
    check("single_idle", busy, 0);

    // queue full, sixth offer held until a slot frees, completion order
    for (int i = 0; i < 5; i++) begin
      jv = 1'b1; jid = 4'(i); jsrc = 10'($urandom); jdst = 10'($urandom);
      tick();
    end
    check("full_ready", job_ready, 0);
    check("full_level", queue_level, 4);
    jid = 4'd5; jsrc = 10'h155; jdst = 10'h2aa;
    repeat (3) tick();
    check("sixth_held", queue_level, 4);
    done = 1'b1; tick(); done = 1'b0;
    tick();
    tick();
    check("slot_freed_level", queue_level, 3);
    check("slot_freed_ready", job_ready, 1);
    tick();
    jv = 1'b0;
    check("sixth_accepted", queue_level, 4);
    exp_id = 1;
    done = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (cmpl_valid && cr) begin
        check("order_id", cmpl_id, exp_id);
        exp_id++;
      end
      tick();
    end
    done = 1'b0;
    check("order_all_seen", exp_id, 6);
    check("order_drained", busy, 0);

    // completion backpressure
    jv = 1'b1; jid = 4'd7; tick(); jid = 4'd8; tick(); jv = 1'b0;
    repeat (3) tick();
    done = 1'b1; tick(); done = 1'b0;
    cr = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("bp_valid", cmpl_valid, 1);
      check("bp_id", cmpl_id, 7);
      check("bp_no_start", tpu_start, 0);
    end
    cr = 1'b1;
    done = 1'b1;
    repeat (10) tick();
    done = 1'b0;

    // spurious done in IDLE and in the start cycle
    done = 1'b1; tick(); done = 1'b0;
    check("spur_idle_rec", cmpl_valid, 0);
    check("spur_idle_busy", busy, 0);
    jv = 1'b1; jid = 4'd9; tick(); jv = 1'b0;
    tick();
    check("spur_start", tpu_start, 1);
    done = 1'b1; tick(); done = 1'b0;
    check("spur_issue_rec", cmpl_valid, 0);
    repeat (3) tick();
    check("spur_still_running", busy, 1);
    done = 1'b1; tick(); done = 1'b0;
    check("spur_real_rec", cmpl_valid, 1);
    repeat (3) tick();

    // watchdog: two jobs, controller never finishes the first
    if (WD) begin
      jv = 1'b1; jid = 4'd10; tick(); jid = 4'd11; tick(); jv = 1'b0;
      aborts = 0;
      for (int c = 0; c < 20; c++) begin
        tick();
        if (tpu_abort) aborts++;
      end
      check("wd_abort_once", aborts, 1);
      done = 1'b1;
      repeat (8) tick();
      done = 1'b0;
      check("wd_next_ok_err", cmpl_err, 0);
      check("wd_drained", busy, 0);
    end

    // reset mid-RUN with jobs queued
    jv = 1'b1;
    for (int i = 0; i < 3; i++) begin
      jid = 4'(12 + i); jsrc = 10'($urandom); tick();
    end
    jv = 1'b0;
    tick();
    srstn = 1'b0; tick(); srstn = 1'b1;
    check("rst_level", queue_level, 0);
    check("rst_busy", busy, 0);
    check("rst_src", tpu_src_base, 0);
    check("rst_count", done_count, 0);
    done = 1'b1;
    repeat (4) tick();
    done = 1'b0;
    check("rst_no_record", cmpl_valid, 0);

    // randomized traffic with occasional reset
    for (int c = 0; c < 3000; c++) begin
      jv    = 1'($urandom_range(0, 1));
      jsrc  = 10'($urandom);
      jdst  = 10'($urandom);
      jid   = 4'($urandom);
      done  = ($urandom_range(0, 5) == 0);
      cr    = ($urandom_range(0, 3) != 0);
      srstn = ($urandom_range(0, 499) != 0);
      tick();
    end
    srstn = 1'b1; jv = 1'b0; done = 1'b1; cr = 1'b1;
    repeat (40) tick();
    check("final_drained", busy, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
